alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers 4-bit ALU commands in a small FIFO and walks each
// one through an external ALU. The sequence is a setup cycle, a single-cycle
// enable pulse, and then a wait for done or a timeout. The 8-bit result is
// then held on a valid/ready handshake until the consumer takes it.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_opcode,
    output logic       alu_enable,
    input  logic [7:0] alu_out,
    input  logic       alu_done,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [1:0] res_op,
    output logic       res_err,
    output logic       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FIRE,
        WAIT,
        HOLD
    } state_e;

    // FIFO storage and bookkeeping
    cmd_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             cmd_ready_q;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    cmd_t             head;

    // Sequencer state and registered outputs
    state_e           state_q;
    logic [TMO_W-1:0] tmo_q;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_b_q;
    logic [1:0]       alu_op_q;
    logic             alu_en_q;
    logic             res_valid_q;
    logic [7:0]       res_data_q;
    logic [1:0]       res_op_q;
    logic             res_err_q;

    // Handshake qualifiers and next occupancy; a pop only happens when the FSM is ready to take a command
    always_comb begin
        fifo_empty = (count_q == '0);
        push       = cmd_valid && cmd_ready_q;
        pop        = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
        head       = mem_q[rd_ptr_q];
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Command storage; contents need no reset because occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
        end
    end

    // FIFO pointers, occupancy and registered ready (ready reflects post-edge occupancy, so a full FIFO never accepts in the same cycle it pops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            cmd_ready_q <= (count_d != FULL_CNT);
        end
    end

    // Sequencer FSM: every ALU-side and result-side output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_a_q  <= head.a;
                        alu_b_q  <= head.b;
                        alu_op_q <= head.op;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Operands have been stable for a full cycle; fire next
                    alu_en_q <= 1'b1;
                    state_q  <= FIRE;
                end
                FIRE: begin
                    alu_en_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        res_data_q  <= alu_out;
                        res_op_q    <= alu_op_q;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (tmo_q == TMO_LAST) begin
                        // ALU never answered: report an error with a zero result
                        res_data_q  <= 8'h00;
                        res_op_q    <= alu_op_q;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (pop) begin
                            // Skip IDLE so back-to-back commands keep a 4-cycle cadence
                            alu_a_q  <= head.a;
                            alu_b_q  <= head.b;
                            alu_op_q <= head.op;
                            state_q  <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    alu_en_q    <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign alu_enable = alu_en_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign res_err    = res_err_q;
    assign busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural ALU answers one cycle after
// each enable pulse. Expected results enter a scoreboard when a command is
// accepted and are checked when the result handshake completes.
module tb_alu_cmd_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic       alu_enable;
    logic [7:0] alu_out_r  = 8'h00;
    logic       alu_done_r = 1'b0;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_op;
    logic       res_err;
    logic       busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        alu_silent = 1'b0;
    logic [10:0] sb_q[$];
    logic [10:0] sb_e;

    alu_cmd_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_enable(alu_enable),
        .alu_out   (alu_out_r),
        .alu_done  (alu_done_r),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: 00 add, 01 subtract (8-bit wrap), 10 multiply, 11 increment a
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return {4'h0, a} + {4'h0, b};
            2'b01:   return {4'h0, a} - {4'h0, b};
            2'b10:   return {4'h0, a} * {4'h0, b};
            default: return {4'h0, a} + 8'd1;
        endcase
    endfunction

    // Downstream ALU: answers on the edge after the enable pulse unless silenced
    always @(posedge clk) begin
        alu_done_r <= alu_enable && !alu_silent;
        if (alu_enable) alu_out_r <= alu_f(alu_a, alu_b, alu_opcode);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted command, pop and compare on accepted result
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready)
            sb_q.push_back({alu_silent, cmd_op,
                            alu_silent ? 8'h00 : alu_f(cmd_a, cmd_b, cmd_op)});
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'(1), 32'(0));
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_result", 32'({res_err, res_op, res_data}), 32'(sb_e));
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        output int acc);
        int k;
        k = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_res(input string tag, output int rc);
        int k;
        k = 0;
        @(negedge clk);
        while (!res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!res_valid) chk(tag, 32'(0), 32'(1));
        rc = cyc;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || res_valid || sb_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(busy || (sb_q.size() != 0)), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int acc, d, r0, r1, r2, r3, seen, k;
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        res_ready = 1'b1;

        // Reset values, applied asynchronously
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_alu_en",    32'(alu_enable), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_res_data",  32'(res_data), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_pre_edge", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("rdy_post_edge", 32'(cmd_ready), 1);

        // Single op: 4+2, latency and enable timing
        @(posedge clk); #1;
        send(4'd4, 4'd2, 2'b00, acc);
        @(negedge clk);
        @(negedge clk);
        chk("issue_en", 32'(alu_enable), 0);
        chk("issue_a",  32'(alu_a), 4);
        chk("issue_b",  32'(alu_b), 2);
        @(negedge clk);
        chk("fire_en",  32'(alu_enable), 1);
        wait_res("single_res", r0);
        chk("single_lat",  32'(r0 - acc), 4);
        chk("single_data", 32'(res_data), 'h06);
        chk("single_op",   32'(res_op), 0);
        chk("single_err",  32'(res_err), 0);
        wait_idle();

        // Burst of four, one result every four cycles
        send(4'd4,  4'd2,  2'b01, acc);
        send(4'd15, 4'd15, 2'b10, d);
        send(4'd15, 4'd0,  2'b11, d);
        send(4'd2,  4'd4,  2'b01, d);
        wait_res("burst0", r0); chk("burst_d0", 32'(res_data), 'h02);
        wait_res("burst1", r1); chk("burst_d1", 32'(res_data), 'hE1);
        wait_res("burst2", r2); chk("burst_d2", 32'(res_data), 'h10);
        wait_res("burst3", r3); chk("burst_d3", 32'(res_data), 'hFE);
        chk("burst_lat",  32'(r0 - acc), 4);
        chk("burst_gap1", 32'(r1 - r0), 4);
        chk("burst_gap2", 32'(r2 - r1), 4);
        chk("burst_gap3", 32'(r3 - r2), 4);
        wait_idle();

        // FIFO full: one in flight plus FIFO_DEPTH queued, next must stall
        res_ready = 1'b0;
        send(4'd1, 4'd1, 2'b00, d);
        send(4'd2, 4'd2, 2'b01, d);
        send(4'd3, 4'd3, 2'b10, d);
        send(4'd4, 4'd4, 2'b11, d);
        send(4'd5, 4'd5, 2'b00, d);
        cmd_a = 4'd6; cmd_b = 4'd6; cmd_op = 2'b10; cmd_valid = 1'b1;
        @(negedge clk);
        chk("full_rdy", 32'(cmd_ready), 0);
        repeat (6) @(negedge clk);
        chk("full_rdy_hold",   32'(cmd_ready), 0);
        chk("full_busy",       32'(busy), 1);
        chk("full_hold_valid", 32'(res_valid), 1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("full_accept_after_pop", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_idle();

        // Backpressure: result held stable, no enable pulses
        res_ready = 1'b0;
        send(4'd9, 4'd3, 2'b10, acc);
        wait_res("bp_res", r0);
        repeat (10) begin
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_data",  32'(res_data), 'h1B);
            chk("bp_en",    32'(alu_enable), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle();

        // Timeout: ALU silent, then a normal command
        alu_silent = 1'b1;
        send(4'd3, 4'd3, 2'b10, acc);
        wait_res("tmo_res", r0);
        chk("tmo_lat",  32'(r0 - acc), 32'(3 + TIMEOUT));
        chk("tmo_err",  32'(res_err), 1);
        chk("tmo_data", 32'(res_data), 0);
        chk("tmo_op",   32'(res_op), 2);
        @(posedge clk);
        #1 alu_silent = 1'b0;
        wait_idle();
        send(4'd7, 4'd1, 2'b01, acc);
        wait_res("post_tmo_res", r0);
        chk("post_tmo_lat",  32'(r0 - acc), 4);
        chk("post_tmo_data", 32'(res_data), 'h06);
        chk("post_tmo_err",  32'(res_err), 0);
        wait_idle();

        // Reset while in WAIT with two commands queued
        alu_silent = 1'b1;
        send(4'd9, 4'd5, 2'b00, acc);
        send(4'd1, 4'd2, 2'b00, d);
        send(4'd3, 4'd4, 2'b01, d);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_a",    32'(alu_a), 9);
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 0);
        chk("mid_rst_busy",      32'(busy), 0);
        chk("mid_rst_alu_en",    32'(alu_enable), 0);
        chk("mid_rst_alu_ops",   32'({alu_a, alu_b, alu_opcode}), 0);
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_res_data",  32'(res_data), 0);
        chk("mid_rst_res_op",    32'(res_op), 0);
        chk("mid_rst_res_err",   32'(res_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        alu_silent = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("post_rst_no_res", 32'(seen), 0);
        chk("post_rst_busy",   32'(busy), 0);

        // Recovery after reset
        @(posedge clk); #1;
        send(4'd8, 4'd8, 2'b10, acc);
        wait_res("recover_res", r0);
        chk("recover_lat",  32'(r0 - acc), 4);
        chk("recover_data", 32'(res_data), 'h40);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
